fc_irq_ctrl: RTL and testbench

Parametrised interrupt controller for the fabric-controller core, succeeding the fixed 32-line event unit. It latches `NB_IRQS` event pulses plus a buffered peripheral event-ID stream into a pending register, applies a mask, and presents the lowest-numbered enabled pending interrupt to the core. The request is emitted either as an ID/req pair (RI5CY style) or as one-hot lines (Ibex fast-IRQ style), and pending bits are retired on the core's acknowledge. It sits between the SoC event sources and the FC core, with a small register port for software configuration.

---
 rtl/fc_irq_pkg.sv | 17 +
 rtl/fc_irq_fifo.sv | 49 ++++
 rtl/fc_irq_ctrl.sv | 131 +++++++++++++
 tb/tb_fc_irq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fc_irq_pkg.sv
// Shared types and constants for the fabric-controller interrupt controller.
package fc_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_state_e;

  localparam logic [1:0] IRQ_REG_MASK = 2'd0;
  localparam logic [1:0] IRQ_REG_PEND = 2'd1;
  localparam logic [1:0] IRQ_REG_FIFO = 2'd2;

  localparam int unsigned OUT_MODE_ID     = 0;
  localparam int unsigned OUT_MODE_ONEHOT = 1;

endpackage

// File: rtl/fc_irq_fifo.sv
// Generic synchronous FIFO with count-based full/empty flags.
module fc_irq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fc_irq_ctrl.sv
// Interrupt controller: pending/mask registers, event-ID FIFO, lowest-index
// arbitration and a req/ack handshake towards the FC core.
module fc_irq_ctrl
  import fc_irq_pkg::*;
#(
  parameter int unsigned NB_IRQS        = 32,
  parameter int unsigned IRQ_ID_WIDTH   = $clog2(NB_IRQS),
  parameter int unsigned EVENT_ID_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FIFO_IRQ_ID    = 26,
  parameter int unsigned OUT_MODE       = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_IRQS-1:0]        events_i,
  input  logic                      event_fifo_valid_i,
  input  logic [EVENT_ID_WIDTH-1:0] event_fifo_data_i,
  output logic                      event_fifo_fulln_o,
  input  logic                      cfg_we_i,
  input  logic                      cfg_re_i,
  input  logic [1:0]                cfg_addr_i,
  input  logic [NB_IRQS-1:0]        cfg_wdata_i,
  output logic [NB_IRQS-1:0]        cfg_rdata_o,
  output logic                      irq_req_o,
  output logic [IRQ_ID_WIDTH-1:0]   irq_id_o,
  output logic [NB_IRQS-1:0]        irq_x_o,
  input  logic                      irq_ack_i,
  input  logic [IRQ_ID_WIDTH-1:0]   irq_ack_id_i
);

  localparam logic [NB_IRQS-1:0] FIFO_BIT = NB_IRQS'(1) << FIFO_IRQ_ID;

  irq_state_e                state_q, state_d;
  logic [NB_IRQS-1:0]        mask_q;
  logic [NB_IRQS-1:0]        pend_q;
  logic [NB_IRQS-1:0]        pend;
  logic [NB_IRQS-1:0]        cand;
  logic [NB_IRQS-1:0]        w1c;
  logic [NB_IRQS-1:0]        ack_clr;
  logic [IRQ_ID_WIDTH-1:0]   win_id;
  logic [IRQ_ID_WIDTH-1:0]   id_q;
  logic [EVENT_ID_WIDTH-1:0] fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;

  assign event_fifo_fulln_o = ~fifo_full;
  assign fifo_push = event_fifo_valid_i & ~fifo_full;
  assign fifo_pop  = cfg_re_i & (cfg_addr_i == IRQ_REG_FIFO);

  fc_irq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_ID_WIDTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (event_fifo_data_i),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The FIFO line is never stored in pend_q; it mirrors FIFO occupancy.
  always_comb begin
    w1c     = (cfg_we_i && cfg_addr_i == IRQ_REG_PEND) ? cfg_wdata_i : '0;
    ack_clr = irq_ack_i ? (NB_IRQS'(1) << irq_ack_id_i) : '0;
    pend    = pend_q | (fifo_empty ? '0 : FIFO_BIT);
    cand    = pend & mask_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      if (cfg_we_i && cfg_addr_i == IRQ_REG_MASK) mask_q <= cfg_wdata_i;
      pend_q <= ((pend_q & ~(w1c | ack_clr)) | events_i) & ~FIFO_BIT;
    end
  end

  always_comb begin
    win_id = '0;
    for (int unsigned i = NB_IRQS; i > 0; i--) begin
      if (cand[i-1]) win_id = IRQ_ID_WIDTH'(i - 1);
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      IRQ_REG_MASK: cfg_rdata_o = mask_q;
      IRQ_REG_PEND: cfg_rdata_o = pend;
      IRQ_REG_FIFO: cfg_rdata_o = fifo_empty ? '0 : NB_IRQS'(fifo_head);
      default:      cfg_rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |cand) id_q <= win_id;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|cand) state_d = REQ;
      REQ: begin
        if (irq_ack_i)      state_d = GAP;
        else if (!cand[id_q]) state_d = IDLE;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_req_o = (state_q == REQ);
    irq_id_o  = id_q;
    irq_x_o   = '0;
    if (OUT_MODE == OUT_MODE_ONEHOT && irq_req_o) irq_x_o = NB_IRQS'(1) << id_q;
  end

endmodule

// File: tb/tb_fc_irq_ctrl.sv
// Directed self-checking bench for fc_irq_ctrl (default and 64-line one-hot builds).
module tb_fc_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned checks = 0;
  int unsigned failures = 0;

  // 32-line, ID/req build
  logic [31:0] ev, wdata, rdata, x;
  logic        fvalid, fulln, we, re, req, ack;
  logic [7:0]  fdata;
  logic [1:0]  addr;
  logic [4:0]  id, ack_id;

  // 64-line, one-hot build
  logic [63:0] ev64, wdata64, rdata64, x64;
  logic        fulln64, we64, req64, ack64;
  logic [1:0]  addr64;
  logic [5:0]  id64, ack_id64;

  always #5 clk = ~clk;

  fc_irq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .events_i(ev),
    .event_fifo_valid_i(fvalid), .event_fifo_data_i(fdata), .event_fifo_fulln_o(fulln),
    .cfg_we_i(we), .cfg_re_i(re), .cfg_addr_i(addr), .cfg_wdata_i(wdata), .cfg_rdata_o(rdata),
    .irq_req_o(req), .irq_id_o(id), .irq_x_o(x), .irq_ack_i(ack), .irq_ack_id_i(ack_id)
  );

  fc_irq_ctrl #(.NB_IRQS(64), .OUT_MODE(1)) dut64 (
    .clk_i(clk), .rst_i(rst), .events_i(ev64),
    .event_fifo_valid_i(1'b0), .event_fifo_data_i(8'h00), .event_fifo_fulln_o(fulln64),
    .cfg_we_i(we64), .cfg_re_i(1'b0), .cfg_addr_i(addr64), .cfg_wdata_i(wdata64), .cfg_rdata_o(rdata64),
    .irq_req_o(req64), .irq_id_o(id64), .irq_x_o(x64), .irq_ack_i(ack64), .irq_ack_id_i(ack_id64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ev = '0; fvalid = 1'b0; fdata = '0; we = 1'b0; re = 1'b0;
    addr = 2'd0; wdata = '0; ack = 1'b0; ack_id = '0;
    ev64 = '0; we64 = 1'b0; addr64 = 2'd0; wdata64 = '0; ack64 = 1'b0; ack_id64 = '0;
    tick(); tick();

    // reset state
    chk("rst_req", req, 0);
    chk("rst_id", id, 0);
    chk("rst_x", x, 0);
    chk("rst_fulln", fulln, 1);
    addr = 2'd0; #1 chk("rst_mask", rdata, 0);
    addr = 2'd1; #1 chk("rst_pend", rdata, 0);
    rst = 1'b0;
    tick();

    // two events, lowest index wins; ack then next request
    we = 1'b1; addr = 2'd0; wdata = 32'hFFFF_FFFF; tick(); we = 1'b0;
    ev = 32'h28; tick();                               // cycle 1
    ev = '0; addr = 2'd1; #1 chk("t1_pend", rdata, 32'h28);
    tick();                                            // cycle 2
    chk("t1_req", req, 1);
    chk("t1_id", id, 3);
    chk("t1_x_mode0", x, 0);
    tick(); tick();                                    // cycle 4
    ack = 1'b1; ack_id = 5'd3; tick();                 // cycle 5
    ack = 1'b0;
    chk("t1_ack_req", req, 0);
    #1 chk("t1_ack_pend", rdata, 32'h20);
    tick();                                            // cycle 6: still in GAP/IDLE path
    chk("t1_gap_req", req, 0);
    tick();                                            // cycle 7
    chk("t1_next_req", req, 1);
    chk("t1_next_id", id, 5);
    ack = 1'b1; ack_id = 5'd5; tick(); ack = 1'b0;
    tick(); tick();
    chk("t1_idle_req", req, 0);
    #1 chk("t1_pend_clear", rdata, 0);

    // masked event, then unmask
    we = 1'b1; addr = 2'd0; wdata = '0; tick(); we = 1'b0;
    ev = 32'h80; tick(); ev = '0; tick();
    chk("t2_masked_req", req, 0);
    addr = 2'd1; #1 chk("t2_pend", rdata, 32'h80);
    we = 1'b1; addr = 2'd0; wdata = 32'h80; tick(); we = 1'b0;
    tick();
    chk("t2_req", req, 1);
    chk("t2_id", id, 7);

    // retract by masking
    we = 1'b1; addr = 2'd0; wdata = '0; tick(); we = 1'b0;
    chk("t3_req_hold", req, 1);
    tick();
    chk("t3_retract", req, 0);
    addr = 2'd1; #1 chk("t3_pend_kept", rdata, 32'h80);
    tick();
    chk("t3_idle", req, 0);

    // event and W1C on the same bit: set wins; bit 7 cleared
    ev = 32'h200; we = 1'b1; addr = 2'd1; wdata = 32'h280; tick();
    ev = '0; we = 1'b0;
    #1 chk("t4_set_wins", rdata, 32'h200);
    we = 1'b1; wdata = 32'h200; tick(); we = 1'b0;
    #1 chk("t4_w1c", rdata, 0);

    // FIFO fill, overflow refusal, ordered drain
    we = 1'b1; addr = 2'd0; wdata = 32'h0400_0000; tick(); we = 1'b0;
    fvalid = 1'b1;
    fdata = 8'h11; tick();
    fdata = 8'h12; tick();
    fdata = 8'h13; tick();
    chk("t5_fulln_3", fulln, 1);
    fdata = 8'h14; tick();
    chk("t5_fulln_4", fulln, 0);
    fdata = 8'h15; tick();
    fvalid = 1'b0;
    chk("t5_fulln_5", fulln, 0);
    chk("t5_req", req, 1);
    chk("t5_id", id, 26);
    addr = 2'd1; #1 chk("t5_pend", rdata, 32'h0400_0000);
    addr = 2'd2; re = 1'b1;
    #1 chk("t5_pop0", rdata, 32'h11); tick();
    chk("t5_pop1", rdata, 32'h12); tick();
    chk("t5_pop2", rdata, 32'h13); tick();
    chk("t5_pop3", rdata, 32'h14); tick();
    chk("t5_empty_read", rdata, 0); tick();
    re = 1'b0;
    chk("t5_fulln_after", fulln, 1);
    addr = 2'd1; #1 chk("t5_pend_after", rdata, 0);
    chk("t5_req_after", req, 0);

    // 64-line one-hot build
    we64 = 1'b1; addr64 = 2'd0; wdata64 = '1; tick(); we64 = 1'b0;
    ev64 = 64'h1 << 40; tick(); ev64 = '0; tick();
    chk("t6_req", req64, 1);
    chk("t6_id", id64, 40);
    chk("t6_x", x64, 64'h1 << 40);
    ack64 = 1'b1; ack_id64 = 6'd40; tick(); ack64 = 1'b0;
    chk("t6_ack_req", req64, 0);
    chk("t6_ack_x", x64, 0);
    ev64 = 64'h1 << 40; tick(); ev64 = '0; tick(); tick();
    chk("t6_req2", req64, 1);
    chk("t6_x2", x64, 64'h1 << 40);
    rst = 1'b1; tick();
    chk("t6_rst_req", req64, 0);
    chk("t6_rst_id", id64, 0);
    chk("t6_rst_x", x64, 0);
    chk("t6_rst_mask", rdata64, 0);
    chk("t6_rst_fulln", fulln64, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
